pwm_multi_ch: RTL and testbench

Parametrised multi-channel PWM generator. It is the successor to the single-channel fixed-ratio PWM in the front-end timing path. A shared prescaler derives a step tick from the system clock, and a shared step counter defines the PWM period. Per-channel duty values are double-buffered, so new duties take effect only at a period boundary and cannot cause glitches. It drives actuator/LED outputs and exports tick and period-start strobes for downstream sequencing.

---
 rtl/pwm_multi_ch.sv | 108 ++++++++++
 tb/tb_pwm_multi_ch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - multi-channel PWM with shared prescaler/step counter and double-buffered duties
module pwm_multi_ch #(
    parameter int CLK_DIV      = 5000,
    parameter int PERIOD_STEPS = 20,
    parameter int DW           = 5,
    parameter int CH           = 4
) (
    input  logic                            clk_50MHz,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [CH*DW-1:0]                duty,
    input  logic                            duty_load,
    input  logic [CH-1:0]                   inv,
    output logic                            tick,
    output logic                            period_start,
    output logic [$clog2(PERIOD_STEPS)-1:0] step,
    output logic [CH-1:0]                   pwm_out
);

    localparam int SW = $clog2(PERIOD_STEPS);
    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0]          pre_cnt, pre_cnt_next;
    logic [SW-1:0]          step_next;
    logic                   run;
    logic                   tick_next, ps_next;
    logic                   pre_wrap, period_wrap, start, boundary;
    logic [CH-1:0][DW-1:0]  duty_act, duty_act_next;
    logic [CH-1:0][DW-1:0]  duty_pend, duty_pend_next;
    logic                   pend_valid, pend_valid_next;
    logic [CH-1:0]          pwm_raw, pwm_raw_next;

    always_comb begin
        pre_cnt_next    = '0;
        step_next       = '0;
        tick_next       = 1'b0;
        ps_next         = 1'b0;
        duty_act_next   = duty_act;
        duty_pend_next  = duty_pend;
        pend_valid_next = pend_valid;
        pwm_raw_next    = '0;

        pre_wrap    = (pre_cnt == PW'(CLK_DIV - 1));
        // the first enabled edge after idle behaves like a period wrap
        start       = en && !run;
        period_wrap = en && run && pre_wrap && (step == SW'(PERIOD_STEPS - 1));
        boundary    = start || period_wrap;

        if (en) begin
            if (start) begin
                ps_next = 1'b1;
            end else begin
                pre_cnt_next = pre_wrap ? '0 : pre_cnt + PW'(1);
                tick_next    = pre_wrap;
                if (pre_wrap) begin
                    step_next = period_wrap ? '0 : step + SW'(1);
                    ps_next   = period_wrap;
                end else begin
                    step_next = step;
                end
            end
        end

        if (!en) begin
            if (duty_load)
                duty_act_next = duty;
        end else if (boundary) begin
            if (duty_load)
                duty_act_next = duty;
            else if (pend_valid)
                duty_act_next = duty_pend;
            pend_valid_next = 1'b0;
        end else if (duty_load) begin
            duty_pend_next  = duty;
            pend_valid_next = 1'b1;
        end

        for (int c = 0; c < CH; c++)
            pwm_raw_next[c] = en && (DW'(step_next) < duty_act_next[c]);
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            step         <= '0;
            run          <= 1'b0;
            tick         <= 1'b0;
            period_start <= 1'b0;
            duty_act     <= '0;
            duty_pend    <= '0;
            pend_valid   <= 1'b0;
            pwm_raw      <= '0;
        end else begin
            pre_cnt      <= pre_cnt_next;
            step         <= step_next;
            run          <= en;
            tick         <= tick_next;
            period_start <= ps_next;
            duty_act     <= duty_act_next;
            duty_pend    <= duty_pend_next;
            pend_valid   <= pend_valid_next;
            pwm_raw      <= pwm_raw_next;
        end
    end

    assign pwm_out = pwm_raw ^ inv;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb/tb_pwm_multi_ch.sv - directed bench for pwm_multi_ch (CLK_DIV=3, PERIOD_STEPS=6, CH=4; plus 2/2 instance)
module tb_pwm_multi_ch;

    logic        clk_50MHz = 1'b0;
    logic        rst_n     = 1'b0;

    logic        en_a = 1'b0;
    logic [11:0] duty_a = '0;
    logic        duty_load_a = 1'b0;
    logic [3:0]  inv_a = '0;
    logic        tick_a, period_start_a;
    logic [2:0]  step_a;
    logic [3:0]  pwm_out_a;

    logic        en_b = 1'b0;
    logic [1:0]  duty_b = '0;
    logic        duty_load_b = 1'b0;
    logic [0:0]  inv_b = '0;
    logic        tick_b, period_start_b;
    logic [0:0]  step_b;
    logic [0:0]  pwm_out_b;

    int errors = 0;
    int checks = 0;

    int         hi [4];
    int         tick_cnt, ps_cnt;
    logic       ps_first;
    logic [3:0] first_out, last_out;

    always #5 clk_50MHz = ~clk_50MHz;

    pwm_multi_ch #(.CLK_DIV(3), .PERIOD_STEPS(6), .DW(3), .CH(4)) dut_a (
        .clk_50MHz    (clk_50MHz),
        .rst_n        (rst_n),
        .en           (en_a),
        .duty         (duty_a),
        .duty_load    (duty_load_a),
        .inv          (inv_a),
        .tick         (tick_a),
        .period_start (period_start_a),
        .step         (step_a),
        .pwm_out      (pwm_out_a)
    );

    pwm_multi_ch #(.CLK_DIV(2), .PERIOD_STEPS(2), .DW(2), .CH(1)) dut_b (
        .clk_50MHz    (clk_50MHz),
        .rst_n        (rst_n),
        .en           (en_b),
        .duty         (duty_b),
        .duty_load    (duty_load_b),
        .inv          (inv_b),
        .tick         (tick_b),
        .period_start (period_start_b),
        .step         (step_b),
        .pwm_out      (pwm_out_b)
    );

    function automatic logic [11:0] pack4(input int d0, input int d1, input int d2, input int d3);
        return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    // Called at the negedge of a period's first cycle; samples 18 cycles, optional load at cycle load_at.
    task automatic measure(input bit do_load, input int load_at, input logic [11:0] vec);
        foreach (hi[c]) hi[c] = 0;
        tick_cnt = 0;
        ps_cnt   = 0;
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk_50MHz);
            if (i == 0) begin
                ps_first  = period_start_a;
                first_out = pwm_out_a;
            end
            if (i == 17) last_out = pwm_out_a;
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out_a[c]);
            tick_cnt += int'(tick_a);
            ps_cnt   += int'(period_start_a);
            duty_load_a = 1'b0;
            if (do_load && i == load_at) begin
                duty_a      = vec;
                duty_load_a = 1'b1;
            end
        end
        @(negedge clk_50MHz);
        duty_load_a = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_50MHz);
        checks++; if (pwm_out_a !== 4'b0000) begin errors++; $display("FAIL reset_pwm_in_reset: got %b expected 0000", pwm_out_a); end
        rst_n = 1'b1;
        @(negedge clk_50MHz);
        checks++; if (step_a !== 3'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step_a); end
        checks++; if (tick_a !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick_a); end
        checks++; if (period_start_a !== 1'b0) begin errors++; $display("FAIL reset_period_start: got %b expected 0", period_start_a); end
        checks++; if (pwm_out_a !== 4'b0000) begin errors++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out_a); end
        inv_a = 4'b0101;
        #1;
        checks++; if (pwm_out_a !== 4'b0101) begin errors++; $display("FAIL reset_inv_passthrough: got %b expected 0101", pwm_out_a); end
        inv_a = 4'b0000;
        @(negedge clk_50MHz);
    endtask

    task automatic test_baseline();
        duty_a      = pack4(4, 0, 0, 0);
        duty_load_a = 1'b1;
        @(negedge clk_50MHz);
        duty_load_a = 1'b0;
        en_a        = 1'b1;
        @(negedge clk_50MHz);
        checks++; if (period_start_a !== 1'b1) begin errors++; $display("FAIL en_rise_period_start: got %b expected 1", period_start_a); end
        checks++; if (step_a !== 3'd0) begin errors++; $display("FAIL en_rise_step: got %0d expected 0", step_a); end
        checks++; if (pwm_out_a !== 4'b0001) begin errors++; $display("FAIL en_rise_pwm: got %b expected 0001", pwm_out_a); end
        measure(1'b0, 0, '0);
        checks++; if (hi[0] !== 12) begin errors++; $display("FAIL baseline_first_high: got %0d expected 12", hi[0]); end
        checks++; if (tick_cnt !== 5) begin errors++; $display("FAIL baseline_first_ticks: got %0d expected 5", tick_cnt); end
        checks++; if (ps_cnt !== 1) begin errors++; $display("FAIL baseline_first_ps: got %0d expected 1", ps_cnt); end
        measure(1'b0, 0, '0);
        checks++; if (ps_first !== 1'b1) begin errors++; $display("FAIL baseline_period_len: got %b expected 1", ps_first); end
        checks++; if (hi[0] !== 12) begin errors++; $display("FAIL baseline_high: got %0d expected 12", hi[0]); end
        checks++; if (tick_cnt !== 6) begin errors++; $display("FAIL baseline_ticks: got %0d expected 6", tick_cnt); end
        checks++; if (hi[1] !== 0) begin errors++; $display("FAIL baseline_ch1_idle: got %0d expected 0", hi[1]); end
    endtask

    task automatic test_duty_sequence();
        int nxt [5];
        int exp_hi [5];
        nxt    = '{5, 2, 6, 1, 0};
        exp_hi = '{12, 15, 6, 18, 3};
        for (int k = 0; k < 5; k++) begin
            measure(k < 4, 8, pack4(nxt[k], 0, 0, 0));
            checks++; if (ps_first !== 1'b1 || hi[0] !== exp_hi[k]) begin errors++; $display("FAIL duty_seq_%0d: got high=%0d ps=%b expected high=%0d ps=1", k, hi[0], ps_first, exp_hi[k]); end
        end
    endtask

    task automatic test_boundaries();
        measure(1'b1, 8, pack4(0, 7, 6, 0));
        checks++; if (hi[0] !== 3) begin errors++; $display("FAIL bound_before_load: got %0d expected 3", hi[0]); end
        for (int k = 0; k < 2; k++) begin
            measure(1'b0, 0, '0);
            checks++; if (hi[0] !== 0) begin errors++; $display("FAIL bound_duty0_%0d: got %0d expected 0", k, hi[0]); end
            checks++; if (hi[1] !== 18) begin errors++; $display("FAIL bound_duty7_%0d: got %0d expected 18", k, hi[1]); end
            checks++; if (hi[2] !== 18) begin errors++; $display("FAIL bound_duty6_%0d: got %0d expected 18", k, hi[2]); end
        end
    endtask

    task automatic test_wrap_load();
        measure(1'b1, 17, pack4(2, 0, 0, 0));
        checks++; if (hi[0] !== 0) begin errors++; $display("FAIL wrap_load_cur: got %0d expected 0", hi[0]); end
        measure(1'b0, 0, '0);
        checks++; if (hi[0] !== 6 || hi[1] !== 0) begin errors++; $display("FAIL wrap_load_applied: got ch0=%0d ch1=%0d expected 6 0", hi[0], hi[1]); end
        measure(1'b1, 16, pack4(5, 0, 0, 0));
        checks++; if (hi[0] !== 6) begin errors++; $display("FAIL pre_wrap_load_cur: got %0d expected 6", hi[0]); end
        measure(1'b0, 0, '0);
        checks++; if (hi[0] !== 15) begin errors++; $display("FAIL pre_wrap_load_applied: got %0d expected 15", hi[0]); end
        measure(1'b1, 0, pack4(1, 0, 0, 0));
        checks++; if (hi[0] !== 15) begin errors++; $display("FAIL post_wrap_load_cur: got %0d expected 15", hi[0]); end
        measure(1'b0, 0, '0);
        checks++; if (hi[0] !== 3) begin errors++; $display("FAIL post_wrap_load_applied: got %0d expected 3", hi[0]); end
    endtask

    task automatic test_multi_inv();
        inv_a = 4'b0100;
        measure(1'b1, 8, pack4(0, 2, 3, 6));
        checks++; if (hi[0] !== 3) begin errors++; $display("FAIL multi_before: got %0d expected 3", hi[0]); end
        measure(1'b0, 0, '0);
        checks++; if (hi[0] !== 0 || hi[1] !== 6) begin errors++; $display("FAIL multi_ch01: got %0d %0d expected 0 6", hi[0], hi[1]); end
        checks++; if (hi[2] !== 9 || hi[3] !== 18) begin errors++; $display("FAIL multi_ch23: got %0d %0d expected 9 18", hi[2], hi[3]); end
        checks++; if (first_out !== 4'b1010) begin errors++; $display("FAIL multi_first_cycle: got %b expected 1010", first_out); end
        checks++; if (last_out !== 4'b1100) begin errors++; $display("FAIL multi_last_cycle: got %b expected 1100", last_out); end
        inv_a = 4'b0000;
    endtask

    task automatic test_enable_drop();
        repeat (4) @(negedge clk_50MHz);
        en_a = 1'b0;
        @(negedge clk_50MHz);
        checks++; if (pwm_out_a !== 4'b0000) begin errors++; $display("FAIL en_drop_pwm: got %b expected 0000", pwm_out_a); end
        checks++; if (step_a !== 3'd0 || tick_a !== 1'b0 || period_start_a !== 1'b0) begin errors++; $display("FAIL en_drop_state: got step=%0d tick=%b ps=%b expected 0 0 0", step_a, tick_a, period_start_a); end
        repeat (2) @(negedge clk_50MHz);
        en_a = 1'b1;
        @(negedge clk_50MHz);
        checks++; if (period_start_a !== 1'b1 || step_a !== 3'd0) begin errors++; $display("FAIL reen_start: got ps=%b step=%0d expected 1 0", period_start_a, step_a); end
        checks++; if (pwm_out_a !== 4'b1110) begin errors++; $display("FAIL reen_pwm: got %b expected 1110", pwm_out_a); end
        measure(1'b0, 0, '0);
        checks++; if (hi[1] !== 6 || hi[2] !== 9 || hi[3] !== 18 || tick_cnt !== 5) begin errors++; $display("FAIL reen_period: got %0d %0d %0d ticks=%0d expected 6 9 18 5", hi[1], hi[2], hi[3], tick_cnt); end
    endtask

    task automatic test_reset_mid();
        int highs;
        repeat (5) @(negedge clk_50MHz);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pwm_out_a !== 4'b0000 || step_a !== 3'd0) begin errors++; $display("FAIL async_reset: got pwm=%b step=%0d expected 0000 0", pwm_out_a, step_a); end
        @(negedge clk_50MHz);
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50MHz);
            highs += int'(pwm_out_a != 4'b0000);
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL post_reset_low: got %0d high cycles expected 0", highs); end
        duty_a      = pack4(3, 0, 0, 0);
        duty_load_a = 1'b1;
        @(negedge clk_50MHz);
        duty_load_a = 1'b0;
        for (int k = 0; k < 40 && !period_start_a; k++) @(negedge clk_50MHz);
        checks++; if (period_start_a !== 1'b1) begin errors++; $display("FAIL post_reset_wait_ps: got %b expected 1", period_start_a); end
        measure(1'b0, 0, '0);
        checks++; if (hi[0] !== 9) begin errors++; $display("FAIL post_reset_load: got %0d expected 9", hi[0]); end
    endtask

    task automatic test_small_params();
        int t, p, h;
        duty_b      = 2'd1;
        duty_load_b = 1'b1;
        @(negedge clk_50MHz);
        duty_load_b = 1'b0;
        en_b        = 1'b1;
        @(negedge clk_50MHz);
        checks++; if (period_start_b !== 1'b1) begin errors++; $display("FAIL small_start: got %b expected 1", period_start_b); end
        repeat (4) @(negedge clk_50MHz);
        t = 0; p = 0; h = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk_50MHz);
            t += int'(tick_b);
            p += int'(period_start_b);
            h += int'(pwm_out_b[0]);
        end
        checks++; if (t !== 4) begin errors++; $display("FAIL small_ticks: got %0d expected 4", t); end
        checks++; if (p !== 2) begin errors++; $display("FAIL small_periods: got %0d expected 2", p); end
        checks++; if (h !== 4) begin errors++; $display("FAIL small_high: got %0d expected 4", h); end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_duty_sequence();
        test_boundaries();
        test_wrap_load();
        test_multi_inv();
        test_enable_drop();
        test_reset_mid();
        test_small_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
